// File: rtl/temp_control_v2.sv
// Hysteretic heat/cool controller with a three-speed cooler, minimum dwell, post-run
// lockout, and a fault state for out-of-range or stale sensor samples.
module temp_control_v2 #(
    parameter int TW        = 8,
    parameter int HEAT_ON   = 15,
    parameter int HEAT_OFF  = 30,
    parameter int COOL_ON   = 35,
    parameter int COOL_OFF  = 25,
    parameter int CRS2      = 40,
    parameter int CRS3      = 45,
    parameter int HYST      = 5,
    parameter int MIN_DWELL = 8,
    parameter int STALE_MAX = 255,
    parameter int T_MIN     = -40,
    parameter int T_MAX     = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 temp_valid,
    input  logic signed [TW-1:0] temperature,
    output logic                 heater,
    output logic                 cooler,
    output logic [3:0]           crs,
    output logic [2:0]           state,
    output logic                 fault
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int SW = $clog2(STALE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEAT    = 3'd1,
        S_COOL    = 3'd2,
        S_LOCKOUT = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [SW-1:0] stale_q, stale_d;
    logic [3:0]    crs_q, crs_d, crs_step;
    logic          heater_q, heater_d;
    logic          cooler_q, cooler_d;
    logic          fault_q, fault_d;

    int   smp;
    logic dwell_done;
    logic out_of_range;
    logic stale_hit;

    always_comb begin
        smp          = temperature;
        dwell_done   = (dwell_q == DW'(MIN_DWELL));
        out_of_range = enable && temp_valid && (smp < T_MIN || smp > T_MAX);

        // Stale counter only runs while enabled; a valid strobe restarts it.
        stale_d = stale_q;
        if (!enable || temp_valid)
            stale_d = '0;
        else if (stale_q != SW'(STALE_MAX))
            stale_d = stale_q + 1'b1;
        stale_hit = enable && (stale_d == SW'(STALE_MAX));

        state_d  = state_q;
        crs_step = crs_q;
        case (state_q)
            S_IDLE: begin
                if (enable && temp_valid) begin
                    if (smp < HEAT_ON)      state_d = S_HEAT;
                    else if (smp > COOL_ON) state_d = S_COOL;
                end
            end
            S_HEAT: begin
                if (!enable)
                    state_d = S_LOCKOUT;
                else if (temp_valid && smp > HEAT_OFF && dwell_done)
                    state_d = S_LOCKOUT;
            end
            S_COOL: begin
                if (!enable) begin
                    state_d = S_LOCKOUT;
                end else if (temp_valid) begin
                    if (smp < COOL_OFF && dwell_done)
                        state_d = S_LOCKOUT;
                    // One speed step per sample, with hysteresis on the way down.
                    case (crs_q)
                        4'd4:    if (smp > CRS2) crs_step = 4'd6;
                        4'd6:    if (smp > CRS3) crs_step = 4'd8;
                                 else if (smp < CRS2 - HYST) crs_step = 4'd4;
                        4'd8:    if (smp < CRS3 - HYST) crs_step = 4'd6;
                        default: crs_step = 4'd4;
                    endcase
                end
            end
            S_LOCKOUT: begin
                if (dwell_q == DW'(MIN_DWELL - 1))
                    state_d = S_IDLE;
            end
            S_FAULT: begin
                if (!enable)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (out_of_range || stale_hit)
            state_d = S_FAULT;

        if (state_d != S_COOL)      crs_d = 4'd0;
        else if (state_q != S_COOL) crs_d = 4'd4;
        else                        crs_d = crs_step;

        if (state_d != state_q) dwell_d = '0;
        else if (dwell_done)    dwell_d = dwell_q;
        else                    dwell_d = dwell_q + 1'b1;

        heater_d = (state_d == S_HEAT);
        cooler_d = (state_d == S_COOL);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dwell_q  <= '0;
            stale_q  <= '0;
            crs_q    <= 4'd0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            stale_q  <= stale_d;
            crs_q    <= crs_d;
            heater_q <= heater_d;
            cooler_q <= cooler_d;
            fault_q  <= fault_d;
        end
    end

    assign heater = heater_q;
    assign cooler = cooler_q;
    assign crs    = crs_q;
    assign state  = state_q;
    assign fault  = fault_q;

endmodule
